// File: rtl/ceespu_branch_ctrl_if.sv
// Branch-controller bundle: decode handshake, forwarded operands, carry write,
// pipeline kill, compare-unit drive/result and front-end redirect controls.
interface ceespu_branch_ctrl_if;
  logic        I_valid;
  logic        O_ready;
  logic [2:0]  I_branchOp;
  logic [31:0] I_target;
  logic        I_opsReady;
  logic [31:0] I_dataA;
  logic [31:0] I_dataB;
  logic        I_carryWe;
  logic        I_carry;
  logic        I_kill;
  logic [31:0] O_cmpA;
  logic [31:0] O_cmpB;
  logic [2:0]  O_cmpOp;
  logic        O_cmpCin;
  logic        I_cmpResult;
  logic        O_stall;
  logic        O_doBranch;
  logic [31:0] O_target;
  logic        O_flush;
  logic        O_carryFlag;

  // Pipeline / compare-unit side
  modport master (
    output I_valid, I_branchOp, I_target, I_opsReady, I_dataA, I_dataB,
    output I_carryWe, I_carry, I_kill, I_cmpResult,
    input  O_ready, O_cmpA, O_cmpB, O_cmpOp, O_cmpCin,
    input  O_stall, O_doBranch, O_target, O_flush, O_carryFlag
  );

  // Branch controller side
  modport slave (
    input  I_valid, I_branchOp, I_target, I_opsReady, I_dataA, I_dataB,
    input  I_carryWe, I_carry, I_kill, I_cmpResult,
    output O_ready, O_cmpA, O_cmpB, O_cmpOp, O_cmpCin,
    output O_stall, O_doBranch, O_target, O_flush, O_carryFlag
  );
endinterface

// File: rtl/ceespu_branch_ctrl.sv
// Branch resolution sequencer: latches one branch, feeds the compare unit from
// registers, then redirects fetch and holds the front end flushed.
module ceespu_branch_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic                 I_clk,
  input logic                 I_rst,
  ceespu_branch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_OPS = 2'd1,
    RESOLVE  = 2'd2,
    FLUSH    = 2'd3
  } state_e;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_e      state_q;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] target_q;
  logic        cin_q;
  logic        carry_q;
  logic [3:0]  cnt_q;
  logic        ready_q;
  logic        stall_q;
  logic        do_branch_q;
  logic        flush_q;
  logic        cin_d;

  // A carry written in the capture cycle must reach the compare unit.
  assign cin_d = bus.I_carryWe ? bus.I_carry : carry_q;

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      carry_q <= 1'b0;
    end else if (bus.I_carryWe) begin
      carry_q <= bus.I_carry;
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q     <= IDLE;
      op_q        <= 3'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      target_q    <= 32'd0;
      cin_q       <= 1'b0;
      cnt_q       <= 4'd0;
      ready_q     <= 1'b1;
      stall_q     <= 1'b0;
      do_branch_q <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      do_branch_q <= 1'b0;
      if (bus.I_kill) begin
        state_q <= IDLE;
        cnt_q   <= 4'd0;
        ready_q <= 1'b1;
        stall_q <= 1'b0;
        flush_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.I_valid) begin
              op_q     <= bus.I_branchOp;
              target_q <= bus.I_target;
              ready_q  <= 1'b0;
              stall_q  <= 1'b1;
              if (bus.I_opsReady) begin
                a_q     <= bus.I_dataA;
                b_q     <= bus.I_dataB;
                cin_q   <= cin_d;
                state_q <= RESOLVE;
              end else begin
                state_q <= WAIT_OPS;
              end
            end
          end
          WAIT_OPS: begin
            if (bus.I_opsReady) begin
              a_q     <= bus.I_dataA;
              b_q     <= bus.I_dataB;
              cin_q   <= cin_d;
              state_q <= RESOLVE;
            end
          end
          RESOLVE: begin
            if (bus.I_cmpResult) begin
              cnt_q       <= FLUSH_INIT;
              do_branch_q <= 1'b1;
              flush_q     <= 1'b1;
              state_q     <= FLUSH;
            end else begin
              ready_q <= 1'b1;
              stall_q <= 1'b0;
              state_q <= IDLE;
            end
          end
          FLUSH: begin
            if (cnt_q == 4'd1) begin
              cnt_q   <= 4'd0;
              ready_q <= 1'b1;
              stall_q <= 1'b0;
              flush_q <= 1'b0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.O_ready     = ready_q;
  assign bus.O_stall     = stall_q;
  assign bus.O_doBranch  = do_branch_q;
  assign bus.O_flush     = flush_q;
  assign bus.O_target    = target_q;
  assign bus.O_cmpA      = a_q;
  assign bus.O_cmpB      = b_q;
  assign bus.O_cmpOp     = op_q;
  assign bus.O_cmpCin    = cin_q;
  assign bus.O_carryFlag = carry_q;

endmodule

// File: tb/tb_ceespu_branch_ctrl.sv
// Bench for ceespu_branch_ctrl: schedule-based reference model checked every
// cycle, plus directed transactions with hand-computed literal expectations.
module tb_ceespu_branch_ctrl;

  localparam int F = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ceespu_branch_ctrl_if bus ();

  ceespu_branch_ctrl #(.FLUSH_CYCLES(F)) dut (
    .I_clk(clk),
    .I_rst(rst),
    .bus  (bus)
  );

  function automatic logic cmp_fn(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic cin);
    case (op)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd2:    return a > b;
      3'd3:    return a >= b;
      3'd4:    return $signed(a) > $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return cin;
      default: return 1'b1;
    endcase
  endfunction

  // External compare unit
  assign bus.I_cmpResult = cmp_fn(bus.O_cmpOp, bus.O_cmpA, bus.O_cmpB, bus.O_cmpCin);

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: timeline of when each observable event must happen.
  int          cyc     = 0;
  bit          m_wait  = 1'b0;
  int          free_at = 0;
  int          res_at  = -1;
  int          db_at   = -1;
  int          fl_lo   = -1;
  int          fl_hi   = -2;
  bit          m_flag  = 1'b0;
  logic [2:0]  m_op    = 3'd0;
  logic [31:0] m_a     = 32'd0;
  logic [31:0] m_b     = 32'd0;
  logic [31:0] m_tgt   = 32'd0;
  logic        m_cin   = 1'b0;

  task automatic model_capture(input int n, input logic cin);
    m_a    = bus.I_dataA;
    m_b    = bus.I_dataB;
    m_cin  = cin;
    res_at = n + 1;
    if (cmp_fn(m_op, m_a, m_b, m_cin)) begin
      db_at   = n + 2;
      fl_lo   = n + 2;
      fl_hi   = n + 1 + F;
      free_at = n + 2 + F;
    end else begin
      free_at = n + 2;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wait = 1'b0; free_at = 0; res_at = -1; db_at = -1;
      fl_lo = -1; fl_hi = -2; m_flag = 1'b0;
    end else begin
      int   n;
      logic cin_now;
      n       = cyc;
      cin_now = bus.I_carryWe ? bus.I_carry : m_flag;
      if (bus.I_kill) begin
        m_wait = 1'b0; free_at = n + 1; res_at = -1; db_at = -1; fl_hi = -2;
      end else if (!m_wait && n >= free_at && bus.I_valid) begin
        m_op  = bus.I_branchOp;
        m_tgt = bus.I_target;
        if (bus.I_opsReady) model_capture(n, cin_now);
        else m_wait = 1'b1;
      end else if (m_wait && bus.I_opsReady) begin
        m_wait = 1'b0;
        model_capture(n, cin_now);
      end
      if (bus.I_carryWe) m_flag = bus.I_carry;
      cyc = n + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int t;
      bit e_ready;
      t       = cyc;
      e_ready = !m_wait && (t >= free_at);
      chk("ready", 32'(bus.O_ready), 32'(e_ready));
      chk("stall", 32'(bus.O_stall), 32'(!e_ready));
      chk("doBranch", 32'(bus.O_doBranch), 32'(t == db_at));
      chk("flush", 32'(bus.O_flush), 32'(t >= fl_lo && t <= fl_hi));
      chk("carryFlag", 32'(bus.O_carryFlag), 32'(m_flag));
      if (t == db_at) chk("target", bus.O_target, m_tgt);
      if (t == res_at) begin
        chk("cmpA", bus.O_cmpA, m_a);
        chk("cmpB", bus.O_cmpB, m_b);
        chk("cmpOp", 32'(bus.O_cmpOp), 32'(m_op));
        chk("cmpCin", 32'(bus.O_cmpCin), 32'(m_cin));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.O_ready && k < 20) begin
      step();
      @(negedge clk);
      k++;
    end
    chk({name, "_ready_timeout"}, 32'(bus.O_ready), 32'd1);
    step();
  endtask

  task automatic present(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] tgt, input logic ops);
    bus.I_branchOp = op;
    bus.I_dataA    = a;
    bus.I_dataB    = b;
    bus.I_target   = tgt;
    bus.I_opsReady = ops;
    bus.I_valid    = 1'b1;
  endtask

  logic [2:0]  v_op [6] = '{3'd2, 3'd3, 3'd5, 3'd4, 3'd0, 3'd1};
  logic [31:0] v_a  [6] = '{32'hFFFFFFFF, 32'd3, 32'h80000000, 32'd5, 32'd1, 32'd1};
  logic [31:0] v_b  [6] = '{32'd1, 32'd3, 32'd0, 32'hFFFFFFFB, 32'd2, 32'd2};
  logic        v_tk [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.I_valid = 1'b0; bus.I_branchOp = 3'd0; bus.I_target = 32'd0;
    bus.I_opsReady = 1'b0; bus.I_dataA = 32'd0; bus.I_dataB = 32'd0;
    bus.I_carryWe = 1'b0; bus.I_carry = 1'b0; bus.I_kill = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(bus.O_ready), 32'd1);
    chk("rst_stall", 32'(bus.O_stall), 32'd0);
    chk("rst_doBranch", 32'(bus.O_doBranch), 32'd0);
    chk("rst_flush", 32'(bus.O_flush), 32'd0);
    chk("rst_carry", 32'(bus.O_carryFlag), 32'd0);
    chk("rst_cmpA", bus.O_cmpA, 32'd0);
    chk("rst_target", bus.O_target, 32'd0);
    step();
    rst = 1'b0;

    // 1: BEQ taken; valid held through busy cycles must be ignored
    present(3'd0, 32'h1234, 32'h1234, 32'h100, 1'b1);
    step();
    @(negedge clk);
    chk("t1_stall", 32'(bus.O_stall), 32'd1);
    chk("t1_ready", 32'(bus.O_ready), 32'd0);
    step();
    @(negedge clk);
    chk("t1_doBranch", 32'(bus.O_doBranch), 32'd1);
    chk("t1_target", bus.O_target, 32'h100);
    chk("t1_flush0", 32'(bus.O_flush), 32'd1);
    step();
    bus.I_valid = 1'b0;
    @(negedge clk);
    chk("t1_flush1", 32'(bus.O_flush), 32'd1);
    chk("t1_db_once", 32'(bus.O_doBranch), 32'd0);
    step();
    @(negedge clk);
    chk("t1_flush_end", 32'(bus.O_flush), 32'd0);
    chk("t1_ready_back", 32'(bus.O_ready), 32'd1);
    $display("txn beq_taken target=0x100");

    // 2: BNE not taken
    present(3'd1, 32'd5, 32'd5, 32'h200, 1'b1);
    step();
    bus.I_valid = 1'b0;
    @(negedge clk);
    chk("t2_stall", 32'(bus.O_stall), 32'd1);
    step();
    @(negedge clk);
    chk("t2_ready", 32'(bus.O_ready), 32'd1);
    chk("t2_doBranch", 32'(bus.O_doBranch), 32'd0);
    chk("t2_flush", 32'(bus.O_flush), 32'd0);
    $display("txn bne_not_taken");

    // 3: BGT signed with operands late by three cycles
    present(3'd4, 32'hFFFFFFFF, 32'd1, 32'h300, 1'b0);
    step();
    bus.I_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_wait_stall", 32'(bus.O_stall), 32'd1);
      chk("t3_wait_ready", 32'(bus.O_ready), 32'd0);
      if (i == 2) bus.I_opsReady = 1'b1;
      step();
    end
    @(negedge clk);
    chk("t3_cmpA", bus.O_cmpA, 32'hFFFFFFFF);
    chk("t3_cmpOp", 32'(bus.O_cmpOp), 32'd4);
    step();
    @(negedge clk);
    chk("t3_ready", 32'(bus.O_ready), 32'd1);
    chk("t3_doBranch", 32'(bus.O_doBranch), 32'd0);
    $display("txn bgt_wait3_not_taken");

    // 4: carry branch with same-cycle carry write
    present(3'd6, 32'd0, 32'd0, 32'h400, 1'b1);
    bus.I_carryWe = 1'b1;
    bus.I_carry   = 1'b1;
    step();
    bus.I_valid = 1'b0; bus.I_carryWe = 1'b0; bus.I_carry = 1'b0;
    @(negedge clk);
    chk("t4_carryFlag", 32'(bus.O_carryFlag), 32'd1);
    chk("t4_cmpCin", 32'(bus.O_cmpCin), 32'd1);
    step();
    @(negedge clk);
    chk("t4_doBranch", 32'(bus.O_doBranch), 32'd1);
    chk("t4_target", bus.O_target, 32'h400);
    wait_ready("t4");
    $display("txn carry_bypass_taken");

    // 5: kill in first flush cycle
    present(3'd7, 32'd0, 32'd9, 32'hDEAD0000, 1'b1);
    step();
    bus.I_valid = 1'b0;
    step();
    bus.I_kill = 1'b1;
    @(negedge clk);
    chk("t5_doBranch", 32'(bus.O_doBranch), 32'd1);
    step();
    bus.I_kill = 1'b0;
    @(negedge clk);
    chk("t5_flush", 32'(bus.O_flush), 32'd0);
    chk("t5_no_second_db", 32'(bus.O_doBranch), 32'd0);
    chk("t5_ready", 32'(bus.O_ready), 32'd1);
    step();
    $display("txn kill_during_flush");

    // Kill beats valid in IDLE
    present(3'd7, 32'd0, 32'd0, 32'h500, 1'b1);
    bus.I_kill = 1'b1;
    step();
    bus.I_valid = 1'b0; bus.I_kill = 1'b0;
    @(negedge clk);
    chk("kp_ready", 32'(bus.O_ready), 32'd1);
    chk("kp_stall", 32'(bus.O_stall), 32'd0);
    step();
    $display("txn kill_priority_over_valid");

    // Condition table
    for (int i = 0; i < 6; i++) begin
      present(v_op[i], v_a[i], v_b[i], 32'h1000 + 32'(i), 1'b1);
      step();
      bus.I_valid = 1'b0;
      step();
      @(negedge clk);
      chk("tbl_doBranch", 32'(bus.O_doBranch), 32'(v_tk[i]));
      wait_ready("tbl");
      $display("txn op=%0d a=0x%08h b=0x%08h taken=%0d", v_op[i], v_a[i], v_b[i], v_tk[i]);
    end

    // 6: asynchronous reset while waiting for operands
    present(3'd0, 32'd7, 32'd7, 32'h600, 1'b0);
    step();
    bus.I_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("t6_ready", 32'(bus.O_ready), 32'd1);
    chk("t6_stall", 32'(bus.O_stall), 32'd0);
    chk("t6_carry", 32'(bus.O_carryFlag), 32'd0);
    chk("t6_doBranch", 32'(bus.O_doBranch), 32'd0);
    chk("t6_flush", 32'(bus.O_flush), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_post_db", 32'(bus.O_doBranch), 32'd0);
    step();
    $display("txn reset_in_wait_ops");

    // Operation resumes after reset
    present(3'd3, 32'd8, 32'd2, 32'h700, 1'b1);
    step();
    bus.I_valid = 1'b0;
    step();
    @(negedge clk);
    chk("post_doBranch", 32'(bus.O_doBranch), 32'd1);
    chk("post_target", bus.O_target, 32'h700);
    wait_ready("post");
    $display("txn geu_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
